// File: rtl/barker_corr_window_if.sv
// barker_corr_window_if: serial-bit input stream and decision output stream of the correlator
interface barker_corr_window_if #(parameter int CW = 4);
    logic s_tdata, s_tvalid, s_tlast, s_tready;
    logic m_tvalid, m_tuser, m_tlast, m_tready;
    logic [CW-1:0] m_tdata;
    modport master(output s_tdata, s_tvalid, s_tlast, m_tready,
                   input s_tready, m_tvalid, m_tuser, m_tdata, m_tlast);
    modport slave(input s_tdata, s_tvalid, s_tlast, m_tready,
                  output s_tready, m_tvalid, m_tuser, m_tdata, m_tlast);
endinterface

// File: rtl/barker_corr_window.sv
// barker_corr_window: serial Barker-style correlator with frame or sliding decisions and match counter
module barker_corr_window #(
    parameter int SEQ_LEN = 11,
    parameter logic [31:0] SEQ_CODE = 32'h0000_0712,
    parameter bit MODE = 1'b0,
    parameter int CW = $clog2(SEQ_LEN + 1)
) (
    input logic i_clk,
    input logic i_rst_n,
    barker_corr_window_if.slave bus,
    input logic [CW-1:0] i_max_err,
    input logic i_cnt_clr,
    output logic [15:0] o_match_cnt
);
    localparam logic [SEQ_LEN-1:0] CODE = SEQ_CODE[SEQ_LEN-1:0];
    // only SEQ_LEN-1 history bits are stored; the incoming bit completes the window
    logic [SEQ_LEN-2:0] win;
    logic [SEQ_LEN-1:0] win_nxt;
    logic [5:0] fill, fill_nxt;
    logic [CW-1:0] err;
    logic accept, full, emit, hs;
    logic [15:0] match_cnt;
    assign bus.s_tready = ~bus.m_tvalid | bus.m_tready;
    assign accept = bus.s_tvalid & bus.s_tready;
    assign hs = bus.m_tvalid & bus.m_tready;
    assign win_nxt = {win, bus.s_tdata};
    assign fill_nxt = (fill == 6'(SEQ_LEN)) ? fill : fill + 6'd1;
    assign full = fill_nxt == 6'(SEQ_LEN);
    assign err = CW'($countones(win_nxt ^ CODE));
    assign emit = accept & (bus.s_tlast | (MODE & full));
    assign o_match_cnt = match_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            win <= '0;
            fill <= '0;
        end else if (accept) begin
            win <= bus.s_tlast ? '0 : win_nxt[SEQ_LEN-2:0];
            fill <= bus.s_tlast ? '0 : fill_nxt;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.m_tvalid <= 1'b0;
            bus.m_tuser <= 1'b0;
            bus.m_tdata <= '0;
            bus.m_tlast <= 1'b0;
        end else if (emit) begin
            bus.m_tvalid <= 1'b1;
            bus.m_tuser <= full & (err <= i_max_err);
            bus.m_tdata <= full ? err : CW'(SEQ_LEN);
            bus.m_tlast <= bus.s_tlast;
        end else if (hs) begin
            bus.m_tvalid <= 1'b0;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) match_cnt <= '0;
        else match_cnt <= i_cnt_clr ? '0 :
                          (hs & bus.m_tuser & ~&match_cnt) ? match_cnt + 16'd1 : match_cnt;
    end
endmodule

// File: tb/tb_barker_corr_window.sv
// tb_barker_corr_window: frame-mode and sliding-mode instances checked against a queue-based model
module tb_barker_corr_window;
    localparam int L = 11;
    localparam int CW = 4;
    logic [L-1:0] code = 11'b11100010010;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [1:0] sd, sv, sl, sr, mv, mu, ml, mr, clr, cnt_load;
    logic [CW-1:0] md [2];
    logic [CW-1:0] me [2];
    logic [15:0] mc [2];
    int total = 0, bad = 0;
    int hs [2];
    logic [CW+1:0] last_out [2];
    barker_corr_window_if #(.CW(CW)) if0 ();
    barker_corr_window_if #(.CW(CW)) if1 ();
    assign if0.s_tdata = sd[0];
    assign if0.s_tvalid = sv[0];
    assign if0.s_tlast = sl[0];
    assign if0.m_tready = mr[0];
    assign if1.s_tdata = sd[1];
    assign if1.s_tvalid = sv[1];
    assign if1.s_tlast = sl[1];
    assign if1.m_tready = mr[1];
    assign sr = {if1.s_tready, if0.s_tready};
    assign mv = {if1.m_tvalid, if0.m_tvalid};
    assign mu = {if1.m_tuser, if0.m_tuser};
    assign ml = {if1.m_tlast, if0.m_tlast};
    assign md[0] = if0.m_tdata;
    assign md[1] = if1.m_tdata;
    barker_corr_window #(.MODE(1'b0)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0),
        .i_max_err(me[0]), .i_cnt_clr(clr[0]), .o_match_cnt(mc[0]));
    barker_corr_window #(.MODE(1'b1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1),
        .i_max_err(me[1]), .i_cnt_clr(clr[1]), .o_match_cnt(mc[1]));

    task automatic chk(string n, int m, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", n, m, a, e, $time);
        end
    endtask

    // model: per instance, the bits of the current frame (newest SEQ_LEN) and pending decisions
    bit fq [2][$];
    logic [CW+1:0] eq [2][$];
    logic [CW+1:0] held [2];
    bit stalled [2];
    logic [15:0] ecnt [2];
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic [CW+1:0] got;
            int mis;
            bit full;
            got = {mu[m], md[m], ml[m]};
            if (!rst_n) begin
                fq[m].delete();
                eq[m].delete();
                ecnt[m] = 16'h0;
                stalled[m] = 1'b0;
            end else begin
                if (cnt_load[m]) ecnt[m] = 16'hFFFF;
                chk("m_tvalid", m, 32'(mv[m]), 32'(eq[m].size() != 0));
                chk("s_tready", m, 32'(sr[m]), 32'(eq[m].size() == 0 || mr[m]));
                chk("match_cnt", m, 32'(mc[m]), 32'(ecnt[m]));
                if (stalled[m] && mv[m]) chk("hold", m, 32'(got), 32'(held[m]));
                if (mv[m] && eq[m].size() != 0) chk("out", m, 32'(got), 32'(eq[m][0]));
                stalled[m] = mv[m] && !mr[m];
                held[m] = got;
                if (clr[m]) ecnt[m] = 16'h0;
                else if (mv[m] && mr[m] && eq[m].size() != 0 && eq[m][0][CW+1] && ecnt[m] != 16'hFFFF)
                    ecnt[m] = ecnt[m] + 16'd1;
                if (mv[m] && mr[m] && eq[m].size() != 0) begin
                    last_out[m] = got;
                    hs[m]++;
                    void'(eq[m].pop_front());
                end
                if (sv[m] && sr[m]) begin
                    fq[m].push_back(sd[m]);
                    if (fq[m].size() > L) void'(fq[m].pop_front());
                    full = fq[m].size() == L;
                    mis = L;
                    if (full) begin
                        mis = 0;
                        for (int i = 0; i < L; i++) if (fq[m][i] != code[L-1-i]) mis++;
                    end
                    if (sl[m] || (m == 1 && full))
                        eq[m].push_back({full && mis <= int'(me[m]), CW'(mis), sl[m]});
                    if (sl[m]) fq[m].delete();
                end
            end
        end
    end

    task automatic send(int m, logic b, logic l);
        int n = 0;
        sv[m] = 1'b1;
        sd[m] = b;
        sl[m] = l;
        @(negedge clk);
        while (!sr[m] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) chk("accept_timeout", m, 32'(n), 32'(0));
        @(posedge clk);
        #1;
        sv[m] = 1'b0;
        sl[m] = 1'b0;
    endtask

    task automatic send_vec(int m, logic [31:0] v, int n, logic last);
        for (int i = n - 1; i >= 0; i--) send(m, v[i], last && i == 0);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sd = '0; sv = '0; sl = '0; mr = 2'b11; clr = '0; cnt_load = '0;
        me[0] = '0; me[1] = '0;
        hs[0] = 0; hs[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 0, 32'(mv), 32'(0));
        chk("rst_user", 0, 32'(mu), 32'(0));
        chk("rst_last", 0, 32'(ml), 32'(0));
        chk("rst_data", 0, 32'(md[0]), 32'(0));
        chk("rst_ready", 0, 32'(sr), 32'(3));
        chk("rst_cnt", 1, 32'(mc[1]), 32'(0));
        rst_n = 1'b1;
        idle(2);
        // exact code, frame mode
        send_vec(0, 32'(code), L, 1'b1);
        idle(3);
        chk("t1_out", 0, 32'(last_out[0]), 32'({1'b1, 4'd0, 1'b1}));
        chk("t1_cnt", 0, 32'(mc[0]), 32'(1));
        chk("t1_beats", 0, 32'(hs[0]), 32'(1));
        // one bit error, then tolerated
        send_vec(0, 32'(11'b11100010011), L, 1'b1);
        idle(3);
        chk("t2_strict", 0, 32'(last_out[0]), 32'({1'b0, 4'd1, 1'b1}));
        me[0] = 4'd1;
        send_vec(0, 32'(11'b11100010011), L, 1'b1);
        idle(3);
        chk("t2_tol", 0, 32'(last_out[0]), 32'({1'b1, 4'd1, 1'b1}));
        chk("t2_cnt", 0, 32'(mc[0]), 32'(2));
        // sliding mode, no tlast
        send_vec(1, 32'h0000_0E24, 16, 1'b0);
        idle(3);
        chk("t3_beats", 1, 32'(hs[1]), 32'(6));
        chk("t3_cnt", 1, 32'(mc[1]), 32'(1));
        chk("t3_lastout", 1, 32'(last_out[1]), 32'({1'b0, 4'd5, 1'b0}));
        send(1, 1'b0, 1'b1);
        idle(3);
        chk("t3_close", 1, 32'(hs[1]), 32'(7));
        // backpressure in sliding mode
        mr[1] = 1'b0;
        fork
            begin
                send_vec(1, 32'(code), L, 1'b0);
                send_vec(1, 32'h1, 3, 1'b1);
            end
            begin
                int n = 0;
                while (!mv[1] && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                repeat (4) @(negedge clk);
                chk("t4_stall_ready", 1, 32'(sr[1]), 32'(0));
                @(posedge clk);
                #1;
                mr[1] = 1'b1;
            end
        join
        idle(3);
        chk("t4_beats", 1, 32'(hs[1]), 32'(11));
        chk("t4_cnt", 1, 32'(mc[1]), 32'(2));
        // short frame then a full one
        me[0] = 4'd0;
        send_vec(0, 32'h16, 5, 1'b1);
        idle(3);
        chk("t5_short", 0, 32'(last_out[0]), 32'({1'b0, 4'd11, 1'b1}));
        send_vec(0, 32'(code), L, 1'b1);
        idle(3);
        chk("t5_full", 0, 32'(last_out[0]), 32'({1'b1, 4'd0, 1'b1}));
        // tolerance at the window length matches anything full
        me[0] = 4'd11;
        send_vec(0, 32'h0, L, 1'b1);
        idle(3);
        chk("maxerr_all", 0, 32'(last_out[0]), 32'({1'b1, 4'd5, 1'b1}));
        chk("maxerr_cnt", 0, 32'(mc[0]), 32'(4));
        me[0] = 4'd0;
        // async reset while a decision is stalled
        mr[0] = 1'b0;
        send_vec(0, 32'(code), L, 1'b1);
        sv[0] = 1'b1;
        sd[0] = 1'b1;
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 0, 32'(mv[0]), 32'(0));
        chk("t6_user", 0, 32'(mu[0]), 32'(0));
        chk("t6_data", 0, 32'(md[0]), 32'(0));
        chk("t6_cnt", 0, 32'(mc[0]), 32'(0));
        sv[0] = 1'b0;
        mr[0] = 1'b1;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send_vec(0, 32'(code), L, 1'b1);
        idle(3);
        chk("t6_after", 0, 32'(last_out[0]), 32'({1'b1, 4'd0, 1'b1}));
        chk("t6_after_cnt", 0, 32'(mc[0]), 32'(1));
        // saturation
        force u0.match_cnt = 16'hFFFF;
        cnt_load[0] = 1'b1;
        idle(1);
        release u0.match_cnt;
        cnt_load[0] = 1'b0;
        send_vec(0, 32'(code), L, 1'b1);
        idle(3);
        chk("sat_cnt", 0, 32'(mc[0]), 32'(16'hFFFF));
        // clear coincident with a matching handshake
        mr[0] = 1'b0;
        send_vec(0, 32'(code), L, 1'b1);
        idle(1);
        mr[0] = 1'b1;
        clr[0] = 1'b1;
        idle(1);
        clr[0] = 1'b0;
        chk("clr_wins", 0, 32'(mc[0]), 32'(0));
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
